// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
// Issue/sequencing controller for an 8-stage pipelined RV32M divider.
// Accepts DIV/DIVU/REM/REMU requests, drives operands straight into the
// divider, tracks every in-flight op in a shadow valid/tag/op pipeline that
// moves in lock-step with the divider registers, freezes the divider when
// the result consumer back-pressures, and applies the RISC-V divide-by-zero
// and signed-overflow results decided at issue time.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready        request handshake
//   in_op                    funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_rs1, in_rs2, in_tag   dividend, divisor, destination tag
//   flush                    kill every in-flight op at the next edge
//   out_valid/out_ready      result handshake
//   out_result, out_tag      final quotient/remainder and its tag
//   busy                     any op in flight
//   div_dividend/div_divisor/div_is_signed/div_stall  to divider
//   div_quotient/div_remainder                         from divider
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  output logic             div_is_signed,
  output logic             div_stall,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder
);

  localparam logic [XLEN-1:0] ZERO_C     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_C     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SIGN_MIN_C = {1'b1, {(XLEN-1){1'b0}}};

  // Shadow pipeline: one entry per divider stage.
  logic [DEPTH-1:0] v_r;
  logic [DEPTH-1:0] is_rem_r;
  logic [DEPTH-1:0] ovr_r;
  logic [TAG_W-1:0] tag_r     [DEPTH];
  logic [XLEN-1:0]  ovr_val_r [DEPTH];

  logic            accept_s;
  logic            special_hit_s;
  logic [XLEN-1:0] special_val_s;

  // Architectural result for the corner cases the divider array does not
  // handle: {hit, value}. Value is the remainder for REM/REMU, else quotient.
  function automatic logic [XLEN:0] special_result(
    input logic [1:0]      op,
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] rs2
  );
    logic            hit;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    hit = 1'b0;
    quo = ZERO_C;
    rem = ZERO_C;
    if (rs2 == ZERO_C) begin
      hit = 1'b1;
      quo = ONES_C;
      rem = rs1;
    end else if (!op[0] && (rs1 == SIGN_MIN_C) && (rs2 == ONES_C)) begin
      hit = 1'b1;
      quo = SIGN_MIN_C;
      rem = ZERO_C;
    end else begin
      hit = 1'b0;
    end
    return {hit, (op[1] ? rem : quo)};
  endfunction

  // Handshake, stall, operand passthrough and result selection.
  always_comb begin
    div_dividend  = in_rs1;
    div_divisor   = in_rs2;
    div_is_signed = ~in_op[0];
    // Freeze only when a finished result is blocked; a flush always lets the
    // divider advance so the shadow pipeline stays aligned with it.
    div_stall     = v_r[DEPTH-1] & ~out_ready & ~flush;
    in_ready      = ~div_stall & ~flush;
    accept_s      = in_valid & in_ready;
    {special_hit_s, special_val_s} = special_result(in_op, in_rs1, in_rs2);
    out_valid     = v_r[DEPTH-1] & ~flush;
    busy          = |v_r;
    out_result    = ZERO_C;
    out_tag       = {TAG_W{1'b0}};
    // Gate data with the valid bit so idle outputs read as zero.
    if (v_r[DEPTH-1]) begin
      out_tag = tag_r[DEPTH-1];
      if (ovr_r[DEPTH-1]) begin
        out_result = ovr_val_r[DEPTH-1];
      end else if (is_rem_r[DEPTH-1]) begin
        out_result = div_remainder;
      end else begin
        out_result = div_quotient;
      end
    end else begin
      out_tag    = {TAG_W{1'b0}};
      out_result = ZERO_C;
    end
  end

  // Shadow pipeline shift/hold; data fields move with the divider even on a
  // flush, only the valid bits are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r      <= {DEPTH{1'b0}};
      is_rem_r <= {DEPTH{1'b0}};
      ovr_r    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i]     <= {TAG_W{1'b0}};
        ovr_val_r[i] <= ZERO_C;
      end
    end else if (!div_stall) begin
      v_r      <= flush ? {DEPTH{1'b0}} : {v_r[DEPTH-2:0], accept_s};
      is_rem_r <= {is_rem_r[DEPTH-2:0], in_op[1]};
      ovr_r    <= {ovr_r[DEPTH-2:0], special_hit_s};
      for (int i = DEPTH - 1; i > 0; i--) begin
        tag_r[i]     <= tag_r[i-1];
        ovr_val_r[i] <= ovr_val_r[i-1];
      end
      tag_r[0]     <= in_tag;
      ovr_val_r[0] <= special_val_s;
    end else begin
      v_r      <= v_r;
      is_rem_r <= is_rem_r;
      ovr_r    <= ovr_r;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
// Self-checking bench for div_issue_ctrl. A stand-in 8-stage divider
// (returning junk for the architectural corner cases) sits behind the DUT.
// Expected behaviour comes from a queue of in-flight ops with their stage
// position and an architectural result computed from the RV32M rules.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  logic             div_is_signed;
  logic             div_stall;
  logic [XLEN-1:0]  div_quotient;
  logic [XLEN-1:0]  div_remainder;

  always #5 clk = ~clk;

  div_issue_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_is_signed(div_is_signed), .div_stall(div_stall),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // ---------------- stand-in divider datapath ----------------
  logic [31:0] dq [DEPTH];
  logic [31:0] dr [DEPTH];

  // Raw divider: junk on the corner cases so the controller must override.
  function automatic logic [63:0] raw_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return {32'hDEAD_BEEF, 32'hBADC_0FFE};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h1234_5678, 32'h8765_4321};
    if (sgn) return {32'(sa / sb), 32'(sa % sb)};
    return {a / b, a % b};
  endfunction

  // Divider pipeline registers, frozen by div_stall.
  always @(posedge clk) begin
    if (!div_stall) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        dq[i] <= dq[i-1];
        dr[i] <= dr[i-1];
      end
      {dq[0], dr[0]} <= raw_div(div_dividend, div_divisor, div_is_signed);
    end
  end
  assign div_quotient  = dq[DEPTH-1];
  assign div_remainder = dr[DEPTH-1];

  // ---------------- reference model ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    int               pos;
  } op_t;
  op_t q_m[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] cur_exp;
  bit obs_valid;
  int stall_seen;
  int valid_seen;
  int retired;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? a % b : a / b;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] t, input logic [31:0] e);
    in_valid = v;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = t;
    cur_exp  = e;
  endtask

  // One clock: compare at the negedge, advance the model, return at posedge+1.
  task automatic step();
    bit head_out;
    bit exp_stall;
    bit exp_ready;
    @(negedge clk);
    head_out  = (q_m.size() > 0) && (q_m[0].pos == DEPTH - 1);
    exp_stall = head_out && !out_ready && !flush;
    exp_ready = !exp_stall && !flush;
    check_eq("div_stall", div_stall, exp_stall);
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, head_out && !flush);
    check_eq("busy", busy, q_m.size() > 0);
    check_eq("div_dividend", div_dividend, in_rs1);
    check_eq("div_is_signed", div_is_signed, !in_op[0]);
    if (head_out && !flush) begin
      check_eq("out_result", out_result, q_m[0].res);
      check_eq("out_tag", out_tag, q_m[0].tag);
    end
    obs_valid  = out_valid;
    stall_seen += div_stall;
    valid_seen += out_valid;
    if (out_valid && out_ready) retired++;
    if (flush) begin
      q_m.delete();
    end else if (!exp_stall) begin
      if (head_out) void'(q_m.pop_front());
      foreach (q_m[i]) q_m[i].pos++;
      if (in_valid && exp_ready) q_m.push_back('{tag: in_tag, res: cur_exp, pos: 0});
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one op from idle and measure cycles to out_valid.
  task automatic issue_timed(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAG_W-1:0] t,
                             input logic [31:0] e);
    int n;
    drive(1'b1, op, a, b, t, e);
    step();
    drive(1'b0, 2'b01, 32'h0, 32'h1, 5'd0, 32'h0);
    n = 0;
    do begin
      step();
      n++;
    end while (!obs_valid && n < 20);
    check_eq(tag, n, 32'd8);
    step();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    stall_seen = 0;
    valid_seen = 0;
    retired = 0;
    drive(1'b0, 2'b01, 32'h0, 32'h1, 5'd0, 32'h0);
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_div_stall", div_stall, 1'b0);
    check_eq("rst_out_result", out_result, 32'h0);
    check_eq("rst_out_tag", out_tag, 5'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Directed results with latency measurement.
    issue_timed("lat_divu", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14);
    issue_timed("lat_remu", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2);
    issue_timed("lat_div", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd5, 32'hFFFF_FFF2);
    issue_timed("lat_rem", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFFE);
    issue_timed("lat_div0", 2'b00, 32'hFFFF_FFF6, 32'h0, 5'd7, 32'hFFFF_FFFF);
    issue_timed("lat_rem0", 2'b10, 32'hFFFF_FFF6, 32'h0, 5'd8, 32'hFFFF_FFF6);
    issue_timed("lat_ovf_div", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
    issue_timed("lat_ovf_rem", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0);

    // Back-to-back issue with a 3-cycle consumer stall.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'b01, 32'(i), 32'd1, 5'(i), 32'(i));
      step();
    end
    drive(1'b0, 2'b01, 32'h0, 32'h1, 5'd0, 32'h0);
    stall_seen = 0;
    retired = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("stall_cycles", stall_seen, 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 30 && q_m.size() > 0; i++) step();
    check_eq("b2b_retired", retired, 32'd8);

    // Flush with 4 ops in flight and a request pending.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b01, 32'd50, 32'd5, 5'(20 + i), 32'd10);
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'b01, 32'h0, 32'h1, 5'd0, 32'h0);
    valid_seen = 0;
    for (int i = 0; i < 12; i++) step();
    check_eq("flush_no_valid", valid_seen, 32'd0);

    // Reset with 5 ops in flight.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b00, 32'd77, 32'd3, 5'(i), 32'd25);
      step();
    end
    drive(1'b0, 2'b01, 32'h0, 32'h1, 5'd0, 32'h0);
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    q_m.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    issue_timed("lat_after_rst", 2'b01, 32'd9, 32'd3, 5'd11, 32'd3);

    // Randomized traffic including corner-case operands.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      drive($urandom_range(0, 3) != 0, op, a, b, 5'($urandom), ref_result(op, a, b));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b01, 32'h0, 32'h1, 5'd0, 32'h0);
    for (int i = 0; i < 40 && q_m.size() > 0; i++) step();
    check_eq("drain_empty", q_m.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
